// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared multi-cycle multiply/divide unit.
// Accepts a muldiv from execute, fires a one-cycle start pulse with latched
// operands, stalls execute until the unit answers, and commits HI/LO once the
// memory bus is free. A flushed operation is drained and its result dropped.
// A watchdog aborts any wait that exceeds TIMEOUT_CYCLES.
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [3:0]  ex_op,
  input  logic [31:0] ex_src_a,
  input  logic [31:0] ex_src_b,
  input  logic        ex_flush,
  input  logic        is_busbusy,
  output logic        md_start,
  output logic        md_sign,
  output logic        md_is_div,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_done,
  input  logic [63:0] md_result,
  output logic        ex_stall,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        md_busy,
  output logic        timeout_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] COMMIT = 3'd3;
  localparam logic [2:0] CANCEL = 3'd4;

  // Last counter value still allowed while waiting on the unit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             op_onehot;
  logic             req;
  logic             accept;
  logic             capture;
  logic             timeout_hit;

  // Malformed opcodes (none or several bits set) are simply not requests.
  assign op_onehot = (ex_op != 4'd0) && ((ex_op & (ex_op - 4'd1)) == 4'd0);
  assign req       = ex_valid & ~ex_flush & op_onehot;

  assign md_start = (state == ISSUE);
  assign md_busy  = (state != IDLE);
  assign hilo_we  = (state == COMMIT) & ~is_busbusy & ~ex_flush;

  // Next-state, stall and per-cycle strobes of the controller.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_nxt   = state;
    ex_stall    = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept    = 1'b1;
          ex_stall  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        ex_stall  = 1'b1;
        state_nxt = ex_flush ? CANCEL : WAIT;
      end
      WAIT: begin
        if (ex_flush) begin
          // A result arriving with the flush is already drained; otherwise
          // wait in CANCEL for the killed operation to finish.
          state_nxt = md_done ? IDLE : CANCEL;
        end else if (md_done) begin
          capture   = 1'b1;
          ex_stall  = 1'b1;
          state_nxt = COMMIT;
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end else begin
          ex_stall = 1'b1;
        end
      end
      COMMIT: begin
        if (ex_flush) begin
          state_nxt = IDLE;
        end else if (is_busbusy) begin
          ex_stall = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      CANCEL: begin
        // Only a new muldiv has to wait for the unit; everything else flows.
        ex_stall = ex_valid & (|ex_op);
        if (md_done) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
      end else if ((state == WAIT) || (state == CANCEL)) begin
        cnt <= cnt + 1'b1;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Operand/attribute latch on accept and result capture from the unit.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: these datapath registers are reset only because downstream logic
    // observes them right after reset; wide data would otherwise stay unreset.
    if (!reset) begin
      md_a      <= '0;
      md_b      <= '0;
      md_sign   <= 1'b0;
      md_is_div <= 1'b0;
      hi_wdata  <= '0;
      lo_wdata  <= '0;
    end else begin
      if (accept) begin
        md_a      <= ex_src_a;
        md_b      <= ex_src_b;
        md_sign   <= ex_op[3] | ex_op[1];
        md_is_div <= ex_op[1] | ex_op[0];
      end
      if (capture) begin
        hi_wdata <= md_result[63:32];
        lo_wdata <= md_result[31:0];
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer. Inputs change on the falling edge and
// outputs are observed 1 ns later; ctl packs {md_start, ex_stall, hilo_we, md_busy}.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [31:0] ex_src_a;
  logic [31:0] ex_src_b;
  logic        ex_flush;
  logic        is_busbusy;
  logic        md_start;
  logic        md_sign;
  logic        md_is_div;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_done;
  logic [63:0] md_result;
  logic        ex_stall;
  logic        hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        md_busy;
  logic        timeout_err;

  logic [3:0]  ctl;
  int          checks = 0;
  int          errors = 0;
  int          start_cnt = 0;
  int          we_cnt = 0;
  int          s0;
  int          w0;

  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b0100;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0001;

  muldiv_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .ex_op      (ex_op),
    .ex_src_a   (ex_src_a),
    .ex_src_b   (ex_src_b),
    .ex_flush   (ex_flush),
    .is_busbusy (is_busbusy),
    .md_start   (md_start),
    .md_sign    (md_sign),
    .md_is_div  (md_is_div),
    .md_a       (md_a),
    .md_b       (md_b),
    .md_done    (md_done),
    .md_result  (md_result),
    .ex_stall   (ex_stall),
    .hilo_we    (hilo_we),
    .hi_wdata   (hi_wdata),
    .lo_wdata   (lo_wdata),
    .md_busy    (md_busy),
    .timeout_err(timeout_err)
  );

  assign ctl = {md_start, ex_stall, hilo_we, md_busy};

  always #5 clk = ~clk;

  // Pulse counters for start and commit strobes.
  always @(posedge clk) begin
    if (md_start) start_cnt <= start_cnt + 1;
    if (hilo_we)  we_cnt    <= we_cnt + 1;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; ex_valid = 1'b0; ex_op = 4'd0; ex_src_a = '0; ex_src_b = '0;
    ex_flush = 1'b0; is_busbusy = 1'b0; md_done = 1'b0; md_result = '0;
    step(); step(); #1;
    checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL reset_ctl: got %b want 0000", ctl); end
    checks++; if ({md_sign, md_is_div, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {md_sign, md_is_div, timeout_err}); end
    checks++; if ({md_a, md_b, hi_wdata, lo_wdata} !== 128'd0) begin errors++; $display("FAIL reset_data: got %h want 0", {md_a, md_b, hi_wdata, lo_wdata}); end
    step(); reset = 1'b1;
  endtask

  task automatic test_mult();
    step(); s0 = start_cnt; w0 = we_cnt;
    ex_valid = 1'b1; ex_op = OP_MULT; ex_src_a = 32'hFFFF_FFFE; ex_src_b = 32'd3; #1;
    checks++; if (ctl !== 4'b0100) begin errors++; $display("FAIL mult_accept: got %b want 0100", ctl); end
    step(); #1;
    checks++; if (ctl !== 4'b1101) begin errors++; $display("FAIL mult_issue: got %b want 1101", ctl); end
    checks++; if ({md_sign, md_is_div} !== 2'b10) begin errors++; $display("FAIL mult_attr: got %b want 10", {md_sign, md_is_div}); end
    checks++; if ({md_a, md_b} !== {32'hFFFF_FFFE, 32'd3}) begin errors++; $display("FAIL mult_opnd: got %h want fffffffe00000003", {md_a, md_b}); end
    for (int i = 2; i <= 4; i++) begin
      step(); #1;
      checks++; if (ctl !== 4'b0101) begin errors++; $display("FAIL mult_wait%0d: got %b want 0101", i, ctl); end
    end
    step(); md_done = 1'b1; md_result = 64'hFFFF_FFFF_FFFF_FFFA; #1;
    checks++; if (ctl !== 4'b0101) begin errors++; $display("FAIL mult_done: got %b want 0101", ctl); end
    step(); md_done = 1'b0; #1;
    checks++; if (ctl !== 4'b0011) begin errors++; $display("FAIL mult_commit: got %b want 0011", ctl); end
    checks++; if ({hi_wdata, lo_wdata} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL mult_hilo: got %h want fffffffffffffffa", {hi_wdata, lo_wdata}); end
    step(); ex_valid = 1'b0; ex_op = 4'd0; #1;
    checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL mult_idle: got %b want 0000", ctl); end
    checks++; if ({start_cnt - s0, we_cnt - w0} !== {32'd1, 32'd1}) begin errors++; $display("FAIL mult_pulses: got start %0d we %0d want 1 1", start_cnt - s0, we_cnt - w0); end
  endtask

  task automatic test_divu_busbusy();
    step(); w0 = we_cnt;
    ex_valid = 1'b1; ex_op = OP_DIVU; ex_src_a = 32'd100; ex_src_b = 32'd7; #1;
    checks++; if (ctl !== 4'b0100) begin errors++; $display("FAIL divu_accept: got %b want 0100", ctl); end
    step(); #1;
    checks++; if ({md_sign, md_is_div} !== 2'b01) begin errors++; $display("FAIL divu_attr: got %b want 01", {md_sign, md_is_div}); end
    step(); md_done = 1'b1; md_result = {32'd2, 32'd14}; #1;
    step(); md_done = 1'b0; is_busbusy = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin step(); #1; end
      checks++; if (ctl !== 4'b0101) begin errors++; $display("FAIL divu_hold%0d: got %b want 0101", i, ctl); end
    end
    step(); is_busbusy = 1'b0; #1;
    checks++; if (ctl !== 4'b0011) begin errors++; $display("FAIL divu_commit: got %b want 0011", ctl); end
    checks++; if ({hi_wdata, lo_wdata} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_hilo: got %h want 000000020000000e", {hi_wdata, lo_wdata}); end
    step(); ex_valid = 1'b0; ex_op = 4'd0; #1;
    checks++; if (we_cnt - w0 !== 1) begin errors++; $display("FAIL divu_we_count: got %0d want 1", we_cnt - w0); end
  endtask

  task automatic test_flush_cancel();
    step(); s0 = start_cnt; w0 = we_cnt;
    ex_valid = 1'b1; ex_op = OP_DIV; ex_src_a = 32'hFFFF_FFEC; ex_src_b = 32'd3;
    step(); #1;
    checks++; if ({md_sign, md_is_div} !== 2'b11) begin errors++; $display("FAIL div_attr: got %b want 11", {md_sign, md_is_div}); end
    step();
    step(); ex_flush = 1'b1; #1;
    checks++; if (ctl !== 4'b0001) begin errors++; $display("FAIL cancel_flush: got %b want 0001", ctl); end
    step(); ex_flush = 1'b0; ex_valid = 1'b0; ex_op = 4'd0; #1;
    checks++; if (ctl !== 4'b0001) begin errors++; $display("FAIL cancel_other: got %b want 0001", ctl); end
    step(); ex_valid = 1'b1; ex_op = OP_MULTU; ex_src_a = 32'd5; ex_src_b = 32'd6; #1;
    checks++; if (ctl !== 4'b0101) begin errors++; $display("FAIL cancel_stall: got %b want 0101", ctl); end
    step(); md_done = 1'b1; md_result = 64'h1234_5678_9ABC_DEF0; #1;
    checks++; if (ctl !== 4'b0101) begin errors++; $display("FAIL cancel_drain: got %b want 0101", ctl); end
    step(); md_done = 1'b0; #1;
    checks++; if (ctl !== 4'b0100) begin errors++; $display("FAIL multu_accept: got %b want 0100", ctl); end
    step(); #1;
    checks++; if ({md_sign, md_is_div, md_a} !== {2'b00, 32'd5}) begin errors++; $display("FAIL multu_issue: got %h want 5 unsigned mul", {md_sign, md_is_div, md_a}); end
    step(); md_done = 1'b1; md_result = {32'd0, 32'd30};
    step(); md_done = 1'b0; #1;
    checks++; if ({ctl, lo_wdata} !== {4'b0011, 32'd30}) begin errors++; $display("FAIL multu_commit: got %h want 3 0000001e", {ctl, lo_wdata}); end
    step(); ex_valid = 1'b0; ex_op = 4'd0; #1;
    checks++; if ({start_cnt - s0, we_cnt - w0} !== {32'd2, 32'd1}) begin errors++; $display("FAIL cancel_pulses: got start %0d we %0d want 2 1", start_cnt - s0, we_cnt - w0); end
  endtask

  task automatic test_flush_races();
    step(); w0 = we_cnt;
    ex_valid = 1'b1; ex_op = OP_MULT; ex_src_a = 32'd1; ex_src_b = 32'd2;
    step();
    step(); md_done = 1'b1; ex_flush = 1'b1; md_result = 64'hDEAD_BEEF_CAFE_F00D; #1;
    checks++; if (ctl !== 4'b0001) begin errors++; $display("FAIL race_wait: got %b want 0001", ctl); end
    step(); md_done = 1'b0; ex_flush = 1'b0; ex_valid = 1'b0; ex_op = 4'd0; #1;
    checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL race_wait_idle: got %b want 0000", ctl); end
    checks++; if ({hi_wdata, lo_wdata} !== {32'd0, 32'd30}) begin errors++; $display("FAIL race_discard: got %h want 000000000000001e", {hi_wdata, lo_wdata}); end
    step(); ex_valid = 1'b1; ex_op = OP_MULTU;
    step();
    step(); md_done = 1'b1; md_result = {32'd11, 32'd22};
    step(); md_done = 1'b0; ex_flush = 1'b1; #1;
    checks++; if (ctl !== 4'b0001) begin errors++; $display("FAIL race_commit: got %b want 0001", ctl); end
    step(); ex_flush = 1'b0; ex_valid = 1'b0; ex_op = 4'd0; #1;
    checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL race_commit_idle: got %b want 0000", ctl); end
    checks++; if (we_cnt - w0 !== 0) begin errors++; $display("FAIL race_we_count: got %0d want 0", we_cnt - w0); end
  endtask

  task automatic test_invalid_op();
    step(); s0 = start_cnt;
    ex_valid = 1'b1; ex_op = 4'b1100; #1;
    checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL multi_hot: got %b want 0000", ctl); end
    step(); ex_op = 4'b0000; #1;
    checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL zero_op: got %b want 0000", ctl); end
    step(); ex_op = OP_MULT; ex_flush = 1'b1; #1;
    checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL flushed_req: got %b want 0000", ctl); end
    step(); ex_flush = 1'b0; ex_valid = 1'b0; ex_op = 4'd0; #1;
    checks++; if ({ctl, start_cnt - s0} !== {4'b0000, 32'd0}) begin errors++; $display("FAIL no_accept: got ctl %b starts %0d want 0000 0", ctl, start_cnt - s0); end
  endtask

  task automatic test_timeout();
    step(); w0 = we_cnt;
    ex_valid = 1'b1; ex_op = OP_MULT; ex_src_a = 32'd9; ex_src_b = 32'd9;
    step();
    for (int c = 2; c <= 64; c++) begin
      step(); #1;
      if (c == 2 || c == 64) begin
        checks++; if ({ctl, timeout_err} !== 5'b01010) begin errors++; $display("FAIL to_wait%0d: got %b want 01010", c, {ctl, timeout_err}); end
      end
    end
    step();
    step(); ex_valid = 1'b0; ex_op = 4'd0; #1;
    checks++; if ({ctl, timeout_err} !== 5'b00001) begin errors++; $display("FAIL to_abort: got %b want 00001", {ctl, timeout_err}); end
    repeat (3) step();
    #1;
    checks++; if ({timeout_err, we_cnt - w0} !== {1'b1, 32'd0}) begin errors++; $display("FAIL to_sticky: got err %b we %0d want 1 0", timeout_err, we_cnt - w0); end
  endtask

  task automatic test_async_reset();
    step(); w0 = we_cnt;
    ex_valid = 1'b1; ex_op = OP_DIV; ex_src_a = 32'd77; ex_src_b = 32'd8;
    step();
    step(); #1;
    checks++; if (ctl !== 4'b0101) begin errors++; $display("FAIL rst_pre: got %b want 0101", ctl); end
    #2 reset = 1'b0; ex_valid = 1'b0; ex_op = 4'd0;
    #1;
    checks++; if ({ctl, md_sign, md_is_div, timeout_err} !== 7'd0) begin errors++; $display("FAIL rst_ctl: got %b want 0000000", {ctl, md_sign, md_is_div, timeout_err}); end
    checks++; if ({md_a, md_b, hi_wdata, lo_wdata} !== 128'd0) begin errors++; $display("FAIL rst_data: got %h want 0", {md_a, md_b, hi_wdata, lo_wdata}); end
    step(); reset = 1'b1; md_done = 1'b1; md_result = 64'hAAAA_BBBB_CCCC_DDDD; #1;
    checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL rst_late_done: got %b want 0000", ctl); end
    step(); md_done = 1'b0; #1;
    checks++; if ({ctl, hi_wdata, we_cnt - w0} !== {4'b0000, 32'd0, 32'd0}) begin errors++; $display("FAIL rst_ignored: got %h want 0", {ctl, hi_wdata, we_cnt - w0}); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu_busbusy();
    test_flush_cancel();
    test_flush_races();
    test_invalid_op();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Runaway guard: the directed sequence is far shorter than this.
  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Controls the shared multi-cycle multiply/divide unit used by the execute stage.
- Accepts MULT/MULTU/DIV/DIVU requests from execute and issues a one-cycle start pulse with latched operands.
- Stalls execute until the result returns, then writes HI/LO once while the memory bus is free.
- Handles pipeline flush during an operation: it drains the unit and discards the result. A watchdog bounds the wait.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT or CANCEL before the operation is aborted.
- CNT_W, 7, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_op  in  4  one-hot {mult, multu, div, divu}.
- ex_src_a  in  32  rs operand.
- ex_src_b  in  32  rt operand.
- ex_flush  in  1  kill the in-flight execute instruction (exception/eret).
- is_busbusy  in  1  memory bus busy; holds the HI/LO commit.
- md_start  out  1  one-cycle start pulse to the unit.
- md_sign  out  1  signed operation (mult/div).
- md_is_div  out  1  1 = divide, 0 = multiply.
- md_a  out  32  latched operand A.
- md_b  out  32  latched operand B.
- md_done  in  1  unit result valid (one-cycle pulse).
- md_result  in  64  {hi, lo}; for divide, hi = remainder and lo = quotient.
- ex_stall  out  1  freeze execute stage.
- hilo_we  out  1  write HI and LO this cycle.
- hi_wdata  out  32  HI write value.
- lo_wdata  out  32  LO write value.
- md_busy  out  1  controller not IDLE.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (reset=0, async): state=IDLE; counter=0; md_a, md_b, hi_wdata, lo_wdata=0. Outputs md_start, md_sign, md_is_div, hilo_we, md_busy and timeout_err are all 0. ex_stall=0.
- Request definition: req = ex_valid & ~ex_flush & ex_op is one-hot. Zero or multiple ex_op bits set means no request (ignored, no error).
- IDLE:
  - If req, latch ex_src_a/ex_src_b into md_a/md_b.
  - Set md_sign = op[3]|op[1] and md_is_div = op[1]|op[0].
  - Go to ISSUE. ex_stall=1 combinationally in the accept cycle.
- ISSUE: md_start=1 for exactly this cycle; ex_stall=1. Next state is WAIT, or CANCEL if ex_flush.
- WAIT:
  - ex_stall=1 and the counter increments.
  - md_done captures md_result[63:32] into hi_wdata and md_result[31:0] into lo_wdata, then goes to COMMIT.
  - ex_flush (no md_done) goes to CANCEL and releases ex_stall that cycle.
  - ex_flush and md_done in the same cycle: flush wins and the state goes to IDLE (result discarded).
- COMMIT:
  - If is_busbusy=0 and ex_flush=0: hilo_we=1 for one cycle, ex_stall=0, go to IDLE.
  - If is_busbusy=1: hold with ex_stall=1 and hilo_we=0.
  - If ex_flush=1: hilo_we=0, ex_stall=0, go to IDLE.
- CANCEL:
  - Waits for md_done from the killed operation, discards it, then goes to IDLE.
  - New requests are not accepted. ex_stall = ex_valid & |ex_op (a new muldiv waits); other instructions proceed.
- md_done is sampled only in WAIT and CANCEL; in IDLE, ISSUE or COMMIT it is ignored. Minimum unit latency is 1 cycle, i.e. md_done no earlier than the cycle after md_start.
- Watchdog:
  - The counter clears on entry to ISSUE and increments in WAIT and CANCEL.
  - At counter==TIMEOUT_CYCLES-1 without md_done: set timeout_err (sticky until reset), go to IDLE, no hilo_we, ex_stall released.
- End-to-end latency: accept at cycle 0, md_start at cycle 1, md_done at 1+N, hilo_we at 2+N when the bus is free.
- Divide by zero is passed to the unit unchanged; whatever md_result returns is committed, and no exception is raised.
- md_busy = (state != IDLE).
- After commit the same instruction leaves execute, so there is no re-accept. A back-to-back muldiv is accepted in the first IDLE cycle.

Test Plan:
- MULT, a=0xFFFFFFFE, b=3, md_done 4 cycles after start, md_result=0xFFFFFFFF_FFFFFFFA -> md_sign=1, md_is_div=0, single md_start pulse. hilo_we at cycle 6 with hi=0xFFFFFFFF, lo=0xFFFFFFFA; ex_stall high cycles 0-5, low at 6.
- DIVU 100/7 with is_busbusy high 3 cycles in COMMIT -> hilo_we delayed exactly 3 cycles, hi=2, lo=14, stall held throughout.
- DIV issued, ex_flush in the 2nd WAIT cycle, a new MULTU presented next -> no hilo_we, state CANCEL. MULTU stalled until md_done drains, then accepted in the IDLE cycle after.
- ex_flush coincident with md_done in WAIT, and separately with COMMIT while the bus is free -> no hilo_we in either case, IDLE next cycle.
- md_done never asserted -> timeout_err rises after TIMEOUT_CYCLES cycles in WAIT, ex_stall drops, timeout_err stays 1 until reset.
- Async reset asserted mid-WAIT (between clock edges) -> all outputs 0 immediately; a late md_done after reset is ignored with no hilo_we.
